// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   oh2idx()             : index of the set bit in a one-hot vector
//                          (up to MAX_CH bits; callers zero-extend and cast)
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++)
      if (oh[i]) idx = IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer resets to 0)
//   req        : per-channel request
//   advance    : a grant was consumed this cycle; move pointer past it
//   grant      : one-hot grant, first requester at or after the pointer
//   grant_idx  : index of the granted channel (0 when no grant)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic             found;

  // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-two N_CH works.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign grant_idx = SEL_W'(oh2idx(MAX_CH'(grant)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance)
      ptr <= (grant_idx == SEL_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer, fixed-select or round-robin.
//   clk, rst_n : clock, async active-low reset
//   mode       : MODE_FIXED (use sel) / MODE_RR (round-robin over valids)
//   sel        : channel index in fixed mode; out-of-range selects nothing
//   in_data    : channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, combinational, at most one high
//   out_data   : registered data of the last accepted beat
//   out_valid  : registered valid
//   out_ready  : consumer ready
//   out_ch     : channel that supplied out_data
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic [N_CH-1:0]             rr_grant, fix_grant, grant;
  logic [SEL_W-1:0]            rr_idx, g_idx;
  logic [N_CH-1:0][WIDTH-1:0]  ch_data;
  logic [WIDTH-1:0]            sel_data;
  logic                        stage_free, accept, advance;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (advance),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Fixed grant ignores in_valid; sel beyond N_CH-1 grants nobody.
  always_comb begin
    fix_grant = '0;
    if ({1'b0, sel} < (SEL_W+1)'(N_CH)) fix_grant[sel] = 1'b1;
  end

  assign grant      = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign g_idx      = (mode == MODE_RR) ? rr_idx : sel;
  assign stage_free = !out_valid || out_ready;
  // rst_n gating keeps producers from seeing ready while held in reset.
  assign in_ready   = (rst_n && stage_free) ? grant : '0;
  assign accept     = |(in_valid & in_ready);
  assign advance    = accept && (mode == MODE_RR);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) sel_data = sel_data | ch_data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= g_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
